// File: rtl/vixen_trace_cache_sa.sv
`default_nettype none
// ============================================================================
// Module   : vixen_trace_cache_sa
// Purpose  : Set-associative trace cache holding decoded micro-op lines tagged
//            by PC and thread ID. Lookups return a registered result one cycle
//            later; decode fills lines on misses; ROB/branch unit flushes all
//            lines of one thread in a single cycle.
// Ports    : clk, rst_n (sync, active-low)
//            lookup_valid/lookup_pc/lookup_tid   -> lookup request
//            hit/miss/hit_thread_id/uops_out/uops_valid -> registered result
//            fill_enable/fill_pc/fill_thread_id/uops_in/valid_in -> fill
//            flush/flush_thread_id                -> per-thread invalidate
//            perf_hits/perf_misses/perf_fills     -> saturating counters
// Revision : 1.0 - initial release
// ============================================================================
module vixen_trace_cache_sa #(
  parameter int NUM_SETS         = 32,
  parameter int WAYS             = 4,
  parameter int UOPS_PER_LINE    = 3,
  parameter int UOP_WIDTH        = 64,
  parameter int NUM_THREADS      = 2,
  parameter int LINE_OFFSET_BITS = 6,
  localparam int TID_W  = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int LINE_W = UOPS_PER_LINE * UOP_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     lookup_valid,
  input  logic [63:0]              lookup_pc,
  input  logic [TID_W-1:0]         lookup_tid,
  output logic                     hit,
  output logic                     miss,
  output logic [TID_W-1:0]         hit_thread_id,
  output logic [LINE_W-1:0]        uops_out,
  output logic [UOPS_PER_LINE-1:0] uops_valid,
  input  logic                     fill_enable,
  input  logic [63:0]              fill_pc,
  input  logic [TID_W-1:0]         fill_thread_id,
  input  logic [LINE_W-1:0]        uops_in,
  input  logic [UOPS_PER_LINE-1:0] valid_in,
  input  logic                     flush,
  input  logic [TID_W-1:0]         flush_thread_id,
  output logic [31:0]              perf_hits,
  output logic [31:0]              perf_misses,
  output logic [31:0]              perf_fills
);

  localparam int SET_BITS = $clog2(NUM_SETS);
  localparam int TAG_W    = 64 - LINE_OFFSET_BITS - SET_BITS;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Line storage. Only the valid bits and replacement pointers need reset.
  logic [WAYS-1:0]          valid_mem [NUM_SETS];
  logic [TAG_W-1:0]         tag_mem   [NUM_SETS][WAYS];
  logic [TID_W-1:0]         tid_mem   [NUM_SETS][WAYS];
  logic [LINE_W-1:0]        data_mem  [NUM_SETS][WAYS];
  logic [UOPS_PER_LINE-1:0] uv_mem    [NUM_SETS][WAYS];
  logic [WAY_W-1:0]         rr_ptr    [NUM_SETS];

  logic [31:0] r_perf_hits;
  logic [31:0] r_perf_misses;
  logic [31:0] r_perf_fills;

  // PC offset bits never take part in tag or index.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[LINE_OFFSET_BITS-1:0], fill_pc[LINE_OFFSET_BITS-1:0]};

  // ---------------------------------------------------------------- lookup
  logic [SET_BITS-1:0] l_idx;
  logic [TAG_W-1:0]    l_tag;
  logic                l_match;
  logic [WAY_W-1:0]    l_way;
  logic                l_hit;

  assign l_idx = lookup_pc[LINE_OFFSET_BITS +: SET_BITS];
  assign l_tag = lookup_pc[63 -: TAG_W];

  always_comb begin
    l_match = 1'b0;
    l_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[l_idx][w] && tag_mem[l_idx][w] == l_tag &&
          tid_mem[l_idx][w] == lookup_tid) begin
        l_match = 1'b1;
        l_way   = WAY_W'(w);
      end
    end
  end

  // A flush of the looked-up thread in the same cycle forces a miss.
  assign l_hit = l_match && !(flush && flush_thread_id == lookup_tid);

  // ------------------------------------------------------------------ fill
  logic [SET_BITS-1:0] f_idx;
  logic [TAG_W-1:0]    f_tag;
  logic                f_match;
  logic [WAY_W-1:0]    f_match_way;
  logic                f_has_inv;
  logic [WAY_W-1:0]    f_inv_way;
  logic [WAY_W-1:0]    f_way;
  logic                f_replace;
  logic                fill_ok;

  assign f_idx = fill_pc[LINE_OFFSET_BITS +: SET_BITS];
  assign f_tag = fill_pc[63 -: TAG_W];

  always_comb begin
    f_match     = 1'b0;
    f_match_way = '0;
    f_has_inv   = 1'b0;
    f_inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_mem[f_idx][w] && tag_mem[f_idx][w] == f_tag &&
          tid_mem[f_idx][w] == fill_thread_id) begin
        f_match     = 1'b1;
        f_match_way = WAY_W'(w);
      end
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mem[f_idx][w]) begin
        f_has_inv = 1'b1;
        f_inv_way = WAY_W'(w);
      end
    end
  end

  assign f_replace = !f_match && !f_has_inv;
  assign f_way     = f_match ? f_match_way : (f_has_inv ? f_inv_way : rr_ptr[f_idx]);
  assign fill_ok   = fill_enable && (|valid_in) &&
                     !(flush && flush_thread_id == fill_thread_id);

  // ------------------------------------------------ valid bits / RR pointers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_mem[s] <= '0;
        rr_ptr[s]    <= '0;
      end
    end else begin
      if (flush) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          for (int w = 0; w < WAYS; w++) begin
            if (tid_mem[s][w] == flush_thread_id) valid_mem[s][w] <= 1'b0;
          end
        end
      end
      // Placed after the flush loop so a fill of another thread wins its way.
      if (fill_ok) begin
        valid_mem[f_idx][f_way] <= 1'b1;
        if (f_replace) begin
          rr_ptr[f_idx] <= (rr_ptr[f_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                : rr_ptr[f_idx] + 1'b1;
        end
      end
    end
  end

  // Payload arrays carry no reset; validity alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (fill_ok) begin
      tag_mem[f_idx][f_way]  <= f_tag;
      tid_mem[f_idx][f_way]  <= fill_thread_id;
      data_mem[f_idx][f_way] <= uops_in;
      uv_mem[f_idx][f_way]   <= valid_in;
    end
  end

  // ------------------------------------------------------- result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit           <= 1'b0;
      miss          <= 1'b0;
      hit_thread_id <= '0;
      uops_out      <= '0;
      uops_valid    <= '0;
    end else begin
      hit           <= lookup_valid && l_hit;
      miss          <= lookup_valid && !l_hit;
      hit_thread_id <= lookup_valid ? lookup_tid : hit_thread_id;
      uops_out      <= (lookup_valid && l_hit) ? data_mem[l_idx][l_way] : '0;
      uops_valid    <= (lookup_valid && l_hit) ? uv_mem[l_idx][l_way] : '0;
    end
  end

  // ------------------------------------------------------ perf counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_hits   <= '0;
      r_perf_misses <= '0;
      r_perf_fills  <= '0;
    end else begin
      if (lookup_valid && l_hit && r_perf_hits != 32'hFFFF_FFFF)
        r_perf_hits <= r_perf_hits + 32'd1;
      if (lookup_valid && !l_hit && r_perf_misses != 32'hFFFF_FFFF)
        r_perf_misses <= r_perf_misses + 32'd1;
      if (fill_ok && r_perf_fills != 32'hFFFF_FFFF)
        r_perf_fills <= r_perf_fills + 32'd1;
    end
  end

  assign perf_hits   = r_perf_hits;
  assign perf_misses = r_perf_misses;
  assign perf_fills  = r_perf_fills;

endmodule
`default_nettype wire

// File: tb/tb_vixen_trace_cache_sa.sv
`default_nettype none
// ============================================================================
// Module   : tb_vixen_trace_cache_sa
// Purpose  : Directed self-checking bench for vixen_trace_cache_sa with
//            default parameters (32 sets, 4 ways, 3 x 64-bit uops, 2 threads).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vixen_trace_cache_sa;

  localparam int TW = 1;
  localparam int LW = 192;

  logic          clk;
  logic          rst_n;
  logic          lookup_valid;
  logic [63:0]   lookup_pc;
  logic [TW-1:0] lookup_tid;
  logic          hit;
  logic          miss;
  logic [TW-1:0] hit_thread_id;
  logic [LW-1:0] uops_out;
  logic [2:0]    uops_valid;
  logic          fill_enable;
  logic [63:0]   fill_pc;
  logic [TW-1:0] fill_thread_id;
  logic [LW-1:0] uops_in;
  logic [2:0]    valid_in;
  logic          flush;
  logic [TW-1:0] flush_thread_id;
  logic [31:0]   perf_hits;
  logic [31:0]   perf_misses;
  logic [31:0]   perf_fills;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] UA = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] UB = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] UC = 64'hCCCC_0000_0000_000C;
  localparam logic [63:0] UD = 64'hDDDD_0000_0000_000D;
  localparam logic [63:0] UE = 64'hEEEE_0000_0000_000E;

  vixen_trace_cache_sa dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lookup_valid    (lookup_valid),
    .lookup_pc       (lookup_pc),
    .lookup_tid      (lookup_tid),
    .hit             (hit),
    .miss            (miss),
    .hit_thread_id   (hit_thread_id),
    .uops_out        (uops_out),
    .uops_valid      (uops_valid),
    .fill_enable     (fill_enable),
    .fill_pc         (fill_pc),
    .fill_thread_id  (fill_thread_id),
    .uops_in         (uops_in),
    .valid_in        (valid_in),
    .flush           (flush),
    .flush_thread_id (flush_thread_id),
    .perf_hits       (perf_hits),
    .perf_misses     (perf_misses),
    .perf_fills      (perf_fills)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // All drives happen right after a falling edge; the rising edge samples
  // them and results are inspected at the next falling edge.
  task automatic lookup(input logic [63:0] pc, input logic [TW-1:0] t);
    lookup_valid = 1'b1; lookup_pc = pc; lookup_tid = t;
    @(negedge clk);
    lookup_valid = 1'b0;
  endtask

  task automatic fill(input logic [63:0] pc, input logic [TW-1:0] t,
                      input logic [LW-1:0] d, input logic [2:0] v);
    fill_enable = 1'b1; fill_pc = pc; fill_thread_id = t; uops_in = d; valid_in = v;
    @(negedge clk);
    fill_enable = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; lookup_valid = 1'b0; lookup_pc = '0; lookup_tid = '0;
    fill_enable = 1'b0; fill_pc = '0; fill_thread_id = '0; uops_in = '0; valid_in = '0;
    flush = 1'b0; flush_thread_id = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    chk("rst_hit", 256'(hit), 256'(0));
    chk("rst_miss", 256'(miss), 256'(0));
    chk("rst_perf_hits", 256'(perf_hits), 256'(0));
    chk("rst_perf_fills", 256'(perf_fills), 256'(0));

    // Cold lookup
    lookup(64'h1000, 1'b0);
    chk("cold_miss", 256'(miss), 256'(1));
    chk("cold_hit", 256'(hit), 256'(0));
    chk("cold_uv", 256'(uops_valid), 256'(0));
    chk("cold_perf_miss", 256'(perf_misses), 256'(1));
    @(negedge clk);
    chk("idle_miss", 256'(miss), 256'(0));

    // Fill then hit; empty-valid fill is ignored
    fill(64'h1000, 1'b0, {UC, UB, UA}, 3'b011);
    chk("fill_cnt1", 256'(perf_fills), 256'(1));
    fill(64'h3000, 1'b0, {UC, UB, UA}, 3'b000);
    chk("fill_novalid", 256'(perf_fills), 256'(1));
    lookup(64'h1000, 1'b0);
    chk("fh_hit", 256'(hit), 256'(1));
    chk("fh_miss", 256'(miss), 256'(0));
    chk("fh_uops", 256'(uops_out), 256'({UC, UB, UA}));
    chk("fh_uv", 256'(uops_valid), 256'(3'b011));
    chk("fh_perf_hits", 256'(perf_hits), 256'(1));
    lookup(64'h1000, 1'b1);
    chk("t1_miss", 256'(miss), 256'(1));
    chk("t1_tid", 256'(hit_thread_id), 256'(1));
    chk("t1_uops", 256'(uops_out), 256'(0));
    lookup(64'h3000, 1'b0);
    chk("novalid_miss", 256'(miss), 256'(1));

    // Replacement in set 0
    do_reset();
    fill(64'h0000, 1'b0, {UA, UA, UA}, 3'b001);
    fill(64'h0800, 1'b0, {UB, UB, UB}, 3'b001);
    fill(64'h1000, 1'b0, {UC, UC, UC}, 3'b001);
    fill(64'h1800, 1'b0, {UD, UD, UD}, 3'b001);
    fill(64'h2000, 1'b0, {UE, UE, UE}, 3'b001);
    chk("rep_fills", 256'(perf_fills), 256'(5));
    lookup(64'h0000, 1'b0);
    chk("rep_evict0", 256'(miss), 256'(1));
    lookup(64'h0800, 1'b0);
    chk("rep_keep1", 256'(hit), 256'(1));
    chk("rep_keep1_d", 256'(uops_out), 256'({UB, UB, UB}));
    lookup(64'h2000, 1'b0);
    chk("rep_new", 256'(uops_out), 256'({UE, UE, UE}));
    fill(64'h2800, 1'b0, {UA, UB, UC}, 3'b111);   // pointer now at way 1
    lookup(64'h0800, 1'b0);
    chk("rep_evict1", 256'(miss), 256'(1));
    lookup(64'h1000, 1'b0);
    chk("rep_keep2", 256'(hit), 256'(1));

    // Flush isolation (fills so far: 6)
    fill(64'h0040, 1'b0, {UD, UD, UD}, 3'b111);
    fill(64'h0040, 1'b1, {UE, UE, UE}, 3'b001);
    flush = 1'b1; flush_thread_id = 1'b0;
    lookup(64'h0040, 1'b0);
    flush = 1'b0;
    chk("fl_same_miss", 256'(miss), 256'(1));
    lookup(64'h0040, 1'b0);
    chk("fl_t0_miss", 256'(miss), 256'(1));
    lookup(64'h0040, 1'b1);
    chk("fl_t1_hit", 256'(hit), 256'(1));
    chk("fl_t1_uops", 256'(uops_out), 256'({UE, UE, UE}));
    chk("fl_t1_uv", 256'(uops_valid), 256'(3'b001));
    flush = 1'b1; flush_thread_id = 1'b0;
    fill(64'h0040, 1'b0, {UA, UA, UA}, 3'b111);
    flush = 1'b0;
    chk("fl_fill_drop_cnt", 256'(perf_fills), 256'(8));
    lookup(64'h0040, 1'b0);
    chk("fl_fill_drop", 256'(miss), 256'(1));

    // Same-cycle fill and lookup
    fill_enable = 1'b1; fill_pc = 64'h80; fill_thread_id = 1'b0;
    uops_in = {UC, UB, UA}; valid_in = 3'b110;
    lookup(64'h80, 1'b0);
    fill_enable = 1'b0;
    chk("sc_miss", 256'(miss), 256'(1));
    lookup(64'h80, 1'b0);
    chk("sc_hit", 256'(hit), 256'(1));
    chk("sc_uv", 256'(uops_valid), 256'(3'b110));

    // Hit counter saturation
    force dut.r_perf_hits = 32'hFFFF_FFFE;
    #1;
    release dut.r_perf_hits;
    chk("sat_preset", 256'(perf_hits), 256'(32'hFFFF_FFFE));
    lookup(64'h80, 1'b0);
    chk("sat_1", 256'(perf_hits), 256'(32'hFFFF_FFFF));
    lookup(64'h80, 1'b0);
    lookup(64'h80, 1'b0);
    chk("sat_3", 256'(perf_hits), 256'(32'hFFFF_FFFF));

    // Reset with a lookup pending
    lookup_valid = 1'b1; lookup_pc = 64'h80; lookup_tid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    lookup_valid = 1'b0; rst_n = 1'b1;
    chk("rl_hit", 256'(hit), 256'(0));
    chk("rl_miss", 256'(miss), 256'(0));
    chk("rl_uops", 256'(uops_out), 256'(0));
    chk("rl_uv", 256'(uops_valid), 256'(0));
    chk("rl_perf_hits", 256'(perf_hits), 256'(0));
    chk("rl_perf_misses", 256'(perf_misses), 256'(0));
    chk("rl_perf_fills", 256'(perf_fills), 256'(0));
    lookup(64'h80, 1'b0);
    chk("rl_cleared", 256'(miss), 256'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vixen_trace_cache_sa.md
Name: vixen_trace_cache_sa

Overview:
- Parametrised set-associative trace cache; next generation of the always-miss core trace cache.
- Stores decoded micro-op lines tagged by PC and thread ID, and returns them on a hit with a registered 1-cycle latency.
- Sits between the fetch/thread-select stage and decode. Decode fills it on misses; the ROB/branch unit flushes it per thread.

Parameters:
- NUM_SETS, 32, number of sets; power of 2, ≥2.
- WAYS, 4, associativity; ≥1.
- UOPS_PER_LINE, 3, micro-op slots per line.
- UOP_WIDTH, 64, bits per micro-op.
- NUM_THREADS, 2, hardware threads; power of 2.
- LINE_OFFSET_BITS, 6, PC bits below the set index (64-byte trace line).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- lookup_valid  in  1  lookup request this cycle
- lookup_pc  in  64  lookup PC
- lookup_tid  in  log2(NUM_THREADS)  lookup thread
- hit  out  1  registered: previous-cycle lookup hit
- miss  out  1  registered: previous-cycle lookup missed
- hit_thread_id  out  log2(NUM_THREADS)  thread of reported lookup
- uops_out  out  UOPS_PER_LINE*UOP_WIDTH  hit line data; slot 0 in LSBs
- uops_valid  out  UOPS_PER_LINE  per-slot valid of hit line
- fill_enable  in  1  fill request
- fill_pc  in  64  fill PC
- fill_thread_id  in  log2(NUM_THREADS)  fill thread
- uops_in  in  UOPS_PER_LINE*UOP_WIDTH  fill data
- valid_in  in  UOPS_PER_LINE  fill slot valids
- flush  in  1  invalidate all lines of flush_thread_id
- flush_thread_id  in  log2(NUM_THREADS)  thread to flush
- perf_hits / perf_misses / perf_fills  out  32 each  saturating event counters

Behaviour:
- Address split:
  - index = pc[LINE_OFFSET_BITS +: log2(NUM_SETS)]
  - tag = pc[63 : LINE_OFFSET_BITS+log2(NUM_SETS)]
  - A way matches when valid && tag equal && stored tid == request tid.
- Reset (rst_n low at a clk edge):
  - All valid bits, round-robin pointers and perf counters clear.
  - hit=0, miss=0, hit_thread_id=0, uops_out=0, uops_valid=0.
  - Reset mid-operation drops any in-flight lookup result.
- Lookup:
  - Sampled at edge N; result valid on outputs during cycle N+1 only.
  - Exactly one of hit/miss is 1 in the cycle after a lookup; both are 0 otherwise.
  - On a miss, uops_out=0 and uops_valid=0.
  - At most one way matches (fills enforce this); the matching way's data and valids drive the outputs.
- Fill:
  - Accepted only if fill_enable && |valid_in; otherwise ignored and not counted.
  - If tag+tid already present in the set, that way is overwritten.
  - Otherwise the victim is the lowest-index invalid way. If no way is invalid, the set's round-robin pointer selects the victim and then increments mod WAYS.
  - The pointer changes only on replacement of a valid line.
  - The line is written with tag, tid, uops_in, valid_in and valid=1; it is visible to lookups from the next cycle.
- Simultaneous lookup and fill to the same set: the lookup sees pre-fill contents (read-before-write).
- Flush:
  - Clears the valid bit of every line whose tid == flush_thread_id, all sets in one cycle; takes effect from the next cycle.
  - Same-cycle lookup of the flushed thread is forced to miss.
  - Same-cycle fill of the flushed thread is dropped and not counted.
  - Other threads are unaffected.
- Perf counters:
  - +1 per reported hit, per reported miss, per accepted fill.
  - Each saturates at 0xFFFFFFFF (no wrap).

Test Plan:
- Cold lookup: after reset, lookup pc=0x1000 tid=0 -> next cycle miss=1, hit=0, uops_valid=0, perf_misses=1.
- Fill then hit: fill pc=0x1000 tid=0 uops={C,B,A} valid_in=3'b011; next cycle lookup 0x1000 tid0 -> hit=1, uops_out={C,B,A}, uops_valid=3'b011. Lookup 0x1000 tid1 -> miss.
- Replacement: fill 5 tags mapping to set 0 (pc=0x0, 0x800, 0x1000, 0x1800, 0x2000) with tid0 -> first 4 land in ways 0–3; 5th evicts way 0. Lookup 0x0 -> miss; 0x800 -> hit.
- Flush isolation: fill 0x40 for tid0 and tid1; flush tid0 -> lookup 0x40 tid0 misses, tid1 hits. Flush with same-cycle tid0 fill -> fill dropped, perf_fills unchanged.
- Same-cycle fill/lookup: fill and lookup 0x80 tid0 in one cycle on an empty set -> miss; repeat the lookup next cycle -> hit.
- Saturation and reset: force perf_hits to 0xFFFFFFFE, perform 3 hits -> 0xFFFFFFFF. Assert rst_n=0 for one edge with a lookup pending -> all outputs 0 the next cycle, counters 0.
